riscv_uncached_ctrl: RTL and testbench
======================================

# riscv_uncached_ctrl

Sequencer for non-cacheable (IO/non-main) data accesses, sitting directly downstream of the PMA checker in the data memory path. It accepts one pipeline request together with the PMA checker's verdict and either returns an immediate fault or performs a single BIU transaction. Cacheable requests belong to the data cache and are ignored here. One access is outstanding at a time; a flush cancels or drains it.

## Interface
- XLEN, 32, data width
- PLEN, XLEN==32 ? 34 : 56, physical address width

Ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- flush_i  in  1  kill the current access; no response is given
- req_i  in  1  access request
- ready_o  out  1  block can accept a request
- adr_i  in  PLEN  physical address
- size_i  in  biu_size_t  transfer size
- we_i  in  1  write
- lock_i  in  1  AMO/locked access
- d_i  in  XLEN  write data
- pma_exception_i  in  1  PMA access fault
- pma_misaligned_i  in  1  misaligned and not permitted by PMA
- pma_cacheable_i  in  1  region is cacheable
- ack_o  out  1  response valid, one-cycle pulse
- q_o  out  XLEN  read data
- exception_o  out  1  access fault response
- misaligned_o  out  1  misaligned response
- err_o  out  1  bus error response
- biu_stb_o  out  1  BIU strobe
- biu_stb_ack_i  in  1  strobe accepted
- biu_d_ack_i  in  1  data phase complete
- biu_err_i  in  1  bus error, terminates the data phase
- biu_adri_o  out  PLEN  BIU address
- biu_size_o  out  biu_size_t  BIU size
- biu_we_o  out  1  BIU write
- biu_lock_o  out  1  BIU lock
- biu_d_o  out  XLEN  BIU write data
- biu_q_i  in  XLEN  BIU read data

## Operation
- A request is accepted when `req_i & ready_o & ~flush_i`. `ready_o = (state==IDLE)`.
- Classification on accept, in priority order:
  - `pma_exception_i`: `ack_o`, `exception_o` next cycle; no bus access.
  - else `pma_misaligned_i`: `ack_o`, `misaligned_o` next cycle.
  - else `pma_cacheable_i`: dropped, no response, state stays IDLE.
  - else: capture adr/size/we/lock/d into the BIU output registers and go to REQ.
- States:
  - IDLE.
  - REQ: `biu_stb_o=1`.
    - `biu_stb_ack_i` → WAIT.
    - `biu_stb_ack_i & (biu_d_ack_i|biu_err_i)` in the same cycle → complete directly.
  - WAIT: `biu_d_ack_i` or `biu_err_i` → complete.
  - DRAIN: a flushed access still outstanding; `biu_d_ack_i|biu_err_i` → IDLE, no response.
- Complete means:
  - `ack_o=1`; `err_o=biu_err_i`.
  - `q_o=biu_q_i` captured for reads only; on writes `q_o` holds its previous value.
  - State → IDLE.
- Flush behaviour:
  - In REQ without `stb_ack`: drop the strobe, go to IDLE.
  - In REQ with `stb_ack` (or in WAIT) without data ack: go to DRAIN.
  - Flush in the completion cycle: suppresses `ack_o`.
  - Flush in IDLE: blocks acceptance.
- `biu_*_o` address/control/data remain stable from REQ entry until completion; `biu_stb_o` deasserts the cycle after `stb_ack`.
- `biu_err_i` and `biu_d_ack_i` together: treat as error.

## Timing
- Reset values: state IDLE; `ack_o`, `exception_o`, `misaligned_o`, `err_o`, `biu_stb_o`, `biu_we_o`, `biu_lock_o` = 0; `q_o`, `biu_adri_o`, `biu_d_o` = 0; `biu_size_o` = BYTE. `ready_o` = 1 in the first cycle after reset.
- Reset mid-operation forces IDLE at once and abandons any outstanding BIU access.
- All outputs are registered except `ready_o`.
- Accept at cycle T (fault path): `ack_o` at T+1.
- Accept at cycle T (bus path):
  - `biu_stb_o` at T+1.
  - With `stb_ack` at T+1 and `d_ack` at T+k, `ack_o` at T+k+1.
  - Minimum latency 2 cycles (combined acks at T+1, `ack_o` at T+2).
- `ack_o`, `exception_o`, `misaligned_o`, `err_o` are single-cycle pulses.
- IDLE is re-entered in the same cycle `ack_o` rises, so a back-to-back request may be accepted in that cycle.

## Structure
- `biu_size_t` and BYTE..QWORD come from `biu_constants_pkg`.
- The state enum (IDLE, REQ, WAIT, DRAIN) is local to the module; no other block uses it.
- Single module, no sub-modules.

## Test plan
- Read at adr 0x4000_0000, WORD, non-cacheable; `stb_ack` at T+1, `d_ack` at T+3 with `biu_q_i=0xDEADBEEF` → `ack_o` at T+4, `q_o=0xDEADBEEF`, `err_o=0`.
- Write `d_i=0x12345678`; `stb_ack` and `d_ack` together at T+1 → `biu_d_o=0x12345678`, `biu_we_o=1`, `ack_o` at T+2.
- `pma_exception_i=1` with `pma_misaligned_i=1` → `ack_o` with `exception_o=1`, `misaligned_o=0` at T+1; `biu_stb_o` never asserted.
- `pma_cacheable_i=1` → no `biu_stb_o`, no `ack_o`, `ready_o` stays 1.
- `flush_i` in WAIT, then `d_ack` 3 cycles later → no `ack_o`; `ready_o` returns 1 the cycle after `d_ack`.
- `biu_err_i` in WAIT → `ack_o=1`, `err_o=1`; `rst_i` asserted in REQ → `biu_stb_o=0` next cycle.

Source files
------------

// File: rtl/biu_constants_pkg.sv
// Shared bus-interface constants: transfer size encoding used by every BIU master.
package biu_constants_pkg;
  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3,
    QWORD = 3'd4
  } biu_size_t;
endpackage

// File: rtl/riscv_uncached_ctrl.sv
// Uncached data-access sequencer: turns one PMA-checked request into either an
// immediate fault response or a single BIU transaction, with flush cancel/drain.
module riscv_uncached_ctrl
  import biu_constants_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PLEN = (XLEN == 32) ? 34 : 56
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            req_i,
  output logic            ready_o,
  input  logic [PLEN-1:0] adr_i,
  input  biu_size_t       size_i,
  input  logic            we_i,
  input  logic            lock_i,
  input  logic [XLEN-1:0] d_i,
  input  logic            pma_exception_i,
  input  logic            pma_misaligned_i,
  input  logic            pma_cacheable_i,
  output logic            ack_o,
  output logic [XLEN-1:0] q_o,
  output logic            exception_o,
  output logic            misaligned_o,
  output logic            err_o,
  output logic            biu_stb_o,
  input  logic            biu_stb_ack_i,
  input  logic            biu_d_ack_i,
  input  logic            biu_err_i,
  output logic [PLEN-1:0] biu_adri_o,
  output biu_size_t       biu_size_o,
  output logic            biu_we_o,
  output logic            biu_lock_o,
  output logic [XLEN-1:0] biu_d_o,
  input  logic [XLEN-1:0] biu_q_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t          r_state, w_state_next;
  logic            r_ack, r_exception, r_misaligned, r_err, r_stb;
  logic            r_we, r_lock;
  logic [XLEN-1:0] r_q, r_d;
  logic [PLEN-1:0] r_adr;
  biu_size_t       r_size;
  logic            w_accept, w_bus_done, w_launch, w_complete;

  assign ready_o    = (r_state == IDLE);
  assign w_accept   = req_i & ready_o & ~flush_i;
  // An error terminates the data phase just like a data ack does.
  assign w_bus_done = biu_d_ack_i | biu_err_i;

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && !pma_exception_i && !pma_misaligned_i && !pma_cacheable_i) begin
          w_state_next = REQ;
          w_launch     = 1'b1;
        end
      end
      REQ: begin
        if (biu_stb_ack_i) begin
          if (w_bus_done) begin
            w_state_next = IDLE;
            w_complete   = ~flush_i;
          end else begin
            w_state_next = flush_i ? DRAIN : WAIT;
          end
        end else if (flush_i) begin
          w_state_next = IDLE;
        end
      end
      WAIT: begin
        if (w_bus_done) begin
          w_state_next = IDLE;
          w_complete   = ~flush_i;
        end else if (flush_i) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_bus_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_ack        <= 1'b0;
      r_exception  <= 1'b0;
      r_misaligned <= 1'b0;
      r_err        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_lock       <= 1'b0;
      r_q          <= '0;
      r_d          <= '0;
      r_adr        <= '0;
      r_size       <= BYTE;
    end else begin
      r_state      <= w_state_next;
      r_ack        <= w_complete | (w_accept & (pma_exception_i | pma_misaligned_i));
      r_exception  <= w_accept & pma_exception_i;
      r_misaligned <= w_accept & ~pma_exception_i & pma_misaligned_i;
      r_err        <= w_complete & biu_err_i;
      r_stb        <= (w_state_next == REQ);
      // Writes leave the last read value visible on q_o.
      if (w_complete && !r_we) r_q <= biu_q_i;
      if (w_launch) begin
        r_adr  <= adr_i;
        r_size <= size_i;
        r_we   <= we_i;
        r_lock <= lock_i;
        r_d    <= d_i;
      end
    end
  end

  assign ack_o        = r_ack;
  assign q_o          = r_q;
  assign exception_o  = r_exception;
  assign misaligned_o = r_misaligned;
  assign err_o        = r_err;
  assign biu_stb_o    = r_stb;
  assign biu_adri_o   = r_adr;
  assign biu_size_o   = r_size;
  assign biu_we_o     = r_we;
  assign biu_lock_o   = r_lock;
  assign biu_d_o      = r_d;

endmodule

// File: tb/tb_riscv_uncached_ctrl.sv
// Bench for riscv_uncached_ctrl: per-transaction stimulus with a BIU responder,
// expected responses queued at issue and checked by an independent ack monitor.
module tb_riscv_uncached_ctrl;
  import biu_constants_pkg::*;

  localparam int XLEN = 32;
  localparam int PLEN = 34;

  logic clk = 1'b0;
  logic rst_i = 1'b1, flush_i = 1'b0, req_i = 1'b0;
  logic [PLEN-1:0] adr_i = '0;
  biu_size_t size_i = BYTE;
  logic we_i = 1'b0, lock_i = 1'b0;
  logic [XLEN-1:0] d_i = '0;
  logic pma_exception_i = 1'b0, pma_misaligned_i = 1'b0, pma_cacheable_i = 1'b0;
  logic biu_stb_ack_i = 1'b0, biu_d_ack_i = 1'b0, biu_err_i = 1'b0;
  logic [XLEN-1:0] biu_q_i = '0;
  logic ready_o, ack_o, exception_o, misaligned_o, err_o, biu_stb_o;
  logic biu_we_o, biu_lock_o;
  logic [XLEN-1:0] q_o, biu_d_o;
  logic [PLEN-1:0] biu_adri_o;
  biu_size_t biu_size_o;

  riscv_uncached_ctrl #(.XLEN(XLEN), .PLEN(PLEN)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .req_i(req_i), .ready_o(ready_o),
    .adr_i(adr_i), .size_i(size_i), .we_i(we_i), .lock_i(lock_i), .d_i(d_i),
    .pma_exception_i(pma_exception_i), .pma_misaligned_i(pma_misaligned_i),
    .pma_cacheable_i(pma_cacheable_i), .ack_o(ack_o), .q_o(q_o),
    .exception_o(exception_o), .misaligned_o(misaligned_o), .err_o(err_o),
    .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i),
    .biu_err_i(biu_err_i), .biu_adri_o(biu_adri_o), .biu_size_o(biu_size_o),
    .biu_we_o(biu_we_o), .biu_lock_o(biu_lock_o), .biu_d_o(biu_d_o), .biu_q_i(biu_q_i)
  );

  always #5 clk = ~clk;

  // fmode: 0 normal, 1 flush in REQ, 2 flush in WAIT, 3 flush at completion, 4 reset in REQ
  typedef struct {
    logic [PLEN-1:0] adr;
    biu_size_t       size;
    logic            we, lock;
    logic [XLEN-1:0] d;
    logic            exc, mis, cach;
    int              stb_wait, d_wait;
    logic            comb, err;
    logic [XLEN-1:0] rdata;
    int              fmode;
  } txn_t;

  typedef struct {
    logic            exc, mis, err;
    logic [XLEN-1:0] q;
  } exp_t;

  exp_t sb[$];
  logic [XLEN-1:0] model_q = '0;
  int n_checks = 0;
  int n_fail   = 0;
  int txn_id   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ack monitor: every response must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack_o === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack_o=1 expected no response at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("resp_exception", exception_o, e.exc);
          chk("resp_misaligned", misaligned_o, e.mis);
          chk("resp_err", err_o, e.err);
          chk("resp_q", q_o, e.q);
        end
      end else if ((exception_o | misaligned_o | err_o) !== 1'b0) begin
        chk("stray_flags", {exception_o, misaligned_o, err_o}, 3'b000);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input txn_t t);
    txn_id++;
    $display("txn %0d: adr=0x%0h we=%0b exc=%0b mis=%0b cach=%0b comb=%0b err=%0b fmode=%0d",
             txn_id, t.adr, t.we, t.exc, t.mis, t.cach, t.comb, t.err, t.fmode);
    chk("ready_at_issue", ready_o, 1);
    req_i = 1'b1; adr_i = t.adr; size_i = t.size; we_i = t.we; lock_i = t.lock; d_i = t.d;
    pma_exception_i = t.exc; pma_misaligned_i = t.mis; pma_cacheable_i = t.cach;
    if (t.exc) sb.push_back('{1'b1, 1'b0, 1'b0, model_q});
    else if (t.mis) sb.push_back('{1'b0, 1'b1, 1'b0, model_q});
    else if (!t.cach && t.fmode == 0) begin
      if (!t.we) model_q = t.rdata;
      sb.push_back('{1'b0, 1'b0, t.err, model_q});
    end
    @(negedge clk);
    req_i = 1'b0; pma_exception_i = 1'b0; pma_misaligned_i = 1'b0; pma_cacheable_i = 1'b0;
    adr_i = {$urandom, 2'b01}; d_i = $urandom; we_i = ~t.we; lock_i = ~t.lock;
    if (t.exc || t.mis) begin
      chk("fault_ack_latency", ack_o, 1);
      chk("fault_no_stb", biu_stb_o, 0);
      return;
    end
    if (t.cach) begin
      chk("cacheable_no_ack", ack_o, 0);
      chk("cacheable_no_stb", biu_stb_o, 0);
      chk("cacheable_ready", ready_o, 1);
      return;
    end
    chk("stb_at_t1", biu_stb_o, 1);
    chk("biu_adr", biu_adri_o, t.adr);
    chk("biu_size", biu_size_o, t.size);
    chk("biu_we", biu_we_o, t.we);
    chk("biu_lock", biu_lock_o, t.lock);
    chk("biu_d", biu_d_o, t.d);
    if (t.fmode == 1) begin
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("flush_req_stb_drop", biu_stb_o, 0);
      chk("flush_req_ready", ready_o, 1);
      return;
    end
    if (t.fmode == 4) begin
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      model_q = '0;
      chk("reset_in_req_stb", biu_stb_o, 0);
      chk("reset_in_req_ready", ready_o, 1);
      return;
    end
    for (int i = 0; i < t.stb_wait; i++) begin
      @(negedge clk);
      chk("stb_held", biu_stb_o, 1);
      chk("adr_stable", biu_adri_o, t.adr);
    end
    biu_stb_ack_i = 1'b1;
    biu_q_i = t.rdata;
    if (t.comb) begin
      biu_err_i = t.err;
      biu_d_ack_i = t.err ? 1'($urandom_range(0, 1)) : 1'b1;
      flush_i = (t.fmode == 3);
      @(negedge clk);
      biu_stb_ack_i = 1'b0; biu_d_ack_i = 1'b0; biu_err_i = 1'b0; flush_i = 1'b0;
      biu_q_i = $urandom;
      chk("comb_ack", ack_o, (t.fmode == 3) ? 1'b0 : 1'b1);
      chk("comb_ready", ready_o, 1);
      return;
    end
    @(negedge clk);
    biu_stb_ack_i = 1'b0;
    biu_q_i = $urandom;
    chk("stb_drop_after_ack", biu_stb_o, 0);
    chk("wait_not_ready", ready_o, 0);
    if (t.fmode == 2) begin
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("drain_not_ready", ready_o, 0);
      @(negedge clk);
      chk("drain_not_ready", ready_o, 0);
      @(negedge clk);
      biu_d_ack_i = 1'b1;
      biu_q_i = t.rdata;
      @(negedge clk);
      biu_d_ack_i = 1'b0;
      chk("drain_no_ack", ack_o, 0);
      chk("drain_ready_after_dack", ready_o, 1);
      return;
    end
    for (int i = 0; i < t.d_wait; i++) begin
      chk("wait_no_ack", ack_o, 0);
      chk("wait_adr_stable", biu_adri_o, t.adr);
      @(negedge clk);
    end
    biu_err_i = t.err;
    biu_d_ack_i = t.err ? 1'($urandom_range(0, 1)) : 1'b1;
    biu_q_i = t.rdata;
    flush_i = (t.fmode == 3);
    @(negedge clk);
    biu_d_ack_i = 1'b0; biu_err_i = 1'b0; flush_i = 1'b0;
    biu_q_i = $urandom;
    chk("wait_ack", ack_o, (t.fmode == 3) ? 1'b0 : 1'b1);
    chk("wait_ready", ready_o, 1);
  endtask

  function automatic txn_t base_txn();
    txn_t t;
    t.adr = {2'b00, $urandom};
    t.size = biu_size_t'($urandom_range(0, 2));
    t.we = 1'($urandom_range(0, 1));
    t.lock = 1'($urandom_range(0, 1));
    t.d = $urandom;
    t.exc = 1'b0; t.mis = 1'b0; t.cach = 1'b0;
    t.stb_wait = $urandom_range(0, 3);
    t.d_wait = $urandom_range(0, 3);
    t.comb = ($urandom_range(0, 3) == 0);
    t.err = ($urandom_range(0, 3) == 0);
    t.rdata = $urandom;
    t.fmode = 0;
    return t;
  endfunction

  initial begin
    txn_t t;
    int kind;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready_o, 1);
    chk("rst_ack", ack_o, 0);
    chk("rst_stb", biu_stb_o, 0);
    chk("rst_flags", {exception_o, misaligned_o, err_o, biu_we_o, biu_lock_o}, 5'b0);
    chk("rst_q", q_o, 0);
    chk("rst_adr", biu_adri_o, 0);
    chk("rst_d", biu_d_o, 0);
    chk("rst_size", biu_size_o, BYTE);
    rst_i = 1'b0;

    t = base_txn(); t.adr = 34'h0_4000_0000; t.size = WORD; t.we = 1'b0; t.comb = 1'b0;
    t.err = 1'b0; t.stb_wait = 0; t.d_wait = 1; t.rdata = 32'hDEADBEEF;
    run_txn(t);
    t = base_txn(); t.we = 1'b1; t.d = 32'h12345678; t.comb = 1'b1; t.err = 1'b0; t.stb_wait = 0;
    run_txn(t);
    t = base_txn(); t.exc = 1'b1; t.mis = 1'b1;
    run_txn(t);
    t = base_txn(); t.cach = 1'b1;
    run_txn(t);
    t = base_txn(); t.comb = 1'b0; t.fmode = 2;
    run_txn(t);
    t = base_txn(); t.we = 1'b0; t.comb = 1'b0; t.err = 1'b1; t.d_wait = 0;
    run_txn(t);
    t = base_txn(); t.fmode = 4;
    run_txn(t);

    // A flushed request in IDLE must not be accepted.
    req_i = 1'b1; flush_i = 1'b1; adr_i = 34'h1_0000_0040;
    @(negedge clk);
    req_i = 1'b0; flush_i = 1'b0;
    chk("flush_idle_no_stb", biu_stb_o, 0);
    chk("flush_idle_ready", ready_o, 1);

    for (int n = 0; n < 80; n++) begin
      t = base_txn();
      kind = $urandom_range(0, 11);
      case (kind)
        0: begin t.exc = 1'b1; t.mis = 1'($urandom_range(0, 1)); t.cach = 1'($urandom_range(0, 1)); end
        1: begin t.mis = 1'b1; t.cach = 1'($urandom_range(0, 1)); end
        2: t.cach = 1'b1;
        3: t.fmode = 1;
        4: begin t.fmode = 2; t.comb = 1'b0; end
        5: t.fmode = 3;
        default: t.fmode = 0;
      endcase
      run_txn(t);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
